// File: rtl/mac_pkg.sv
// Shared definitions for the MAC operand sequencer: instruction encodings,
// operand width and the sequencer state enum.
package mac_pkg;

  localparam int OP_W = 16;

  localparam logic [2:0] INSTR_CLR = 3'b000;
  localparam logic [2:0] INSTR_MUL = 3'b001;
  localparam logic [2:0] INSTR_ACC = 3'b010;
  localparam logic [2:0] INSTR_SAT = 3'b011;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FIRST = 3'd1,
    ST_ACC   = 3'd2,
    ST_SAT   = 3'd3,
    ST_DRAIN = 3'd4
  } seq_state_e;

endpackage

// File: rtl/mac_op_fifo.sv
// Operand-pair FIFO: DEPTH entries, pointers carry an extra wrap bit so
// full and empty are told apart without a separate counter.
module mac_op_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage needs no reset: the pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/mac_dot_seq.sv
// Dot-product job sequencer feeding the 16x16 MAC. The state register and
// the instruction/operand registers load together, so the state seen in a
// cycle is the state whose instruction the MAC samples at that negedge.
module mac_dot_seq
  import mac_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             job_valid,
  output logic             job_ready,
  input  logic [LEN_W-1:0] job_len,
  input  logic             job_sat,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [OP_W-1:0]  op_a,
  input  logic [OP_W-1:0]  op_b,
  output logic [2:0]       instruction,
  output logic [OP_W-1:0]  multiplier,
  output logic [OP_W-1:0]  multiplicand,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [2:0]       dbg_state
);

  // Handshakes: a job is taken on job_valid && job_ready, an operand pair on
  // op_valid && op_ready; both readies depend on registers only and are held
  // low during reset and for the reset edge itself.

  localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

  seq_state_e       state_q, state_n;
  logic [LEN_W-1:0] rem_q, rem_n;
  logic             sat_q, sat_n;
  logic             stall_q, stall_n;
  logic             done_q, done_n;
  logic             run_q;
  logic [2:0]       instr_q, instr_n;
  logic [OP_W-1:0]  mplr_q, mplr_n;
  logic [OP_W-1:0]  mcnd_q, mcnd_n;

  logic             job_accept;
  logic             issue_slot;
  logic             fifo_push;
  logic             fifo_pop;
  logic [2*OP_W-1:0] fifo_dout;
  logic             fifo_full;
  logic             fifo_empty;

  mac_op_fifo #(
    .DEPTH (DEPTH),
    .W     (2*OP_W)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (fifo_push),
    .din     ({op_a, op_b}),
    .pop     (fifo_pop),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign job_ready    = run_q && (state_q == ST_IDLE);
  assign op_ready     = run_q && !fifo_full;
  assign fifo_push    = op_valid && op_ready;
  assign job_accept   = job_valid && job_ready;
  assign busy         = (state_q != ST_IDLE);
  assign instruction  = instr_q;
  assign multiplier   = mplr_q;
  assign multiplicand = mcnd_q;
  assign stall        = stall_q;
  assign done         = done_q;
  assign dbg_state    = state_q;

  always_comb begin
    state_n    = state_q;
    rem_n      = rem_q;
    sat_n      = sat_q;
    stall_n    = 1'b0;
    done_n     = 1'b0;
    instr_n    = INSTR_ACC;
    mplr_n     = '0;
    mcnd_n     = '0;
    fifo_pop   = 1'b0;
    issue_slot = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (job_accept) begin
          state_n    = ST_FIRST;
          rem_n      = job_len;
          sat_n      = job_sat && (job_len != '0);
          issue_slot = 1'b1;
        end
      end
      ST_FIRST: begin
        if (stall_q) begin
          issue_slot = 1'b1;
        end else if (rem_q != '0) begin
          state_n    = ST_ACC;
          issue_slot = 1'b1;
        end else if (sat_q) begin
          state_n = ST_SAT;
          instr_n = INSTR_SAT;
        end else begin
          state_n = ST_DRAIN;
        end
      end
      ST_ACC: begin
        if (rem_q != '0) begin
          issue_slot = 1'b1;
        end else if (sat_q) begin
          state_n = ST_SAT;
          instr_n = INSTR_SAT;
        end else begin
          state_n = ST_DRAIN;
        end
      end
      ST_SAT: state_n = ST_DRAIN;
      ST_DRAIN: begin
        state_n = ST_IDLE;
        sat_n   = 1'b0;
        done_n  = 1'b1;
      end
      default: state_n = ST_IDLE;
    endcase

    // Only a zero-length job enters a slot with nothing left to issue.
    if (issue_slot) begin
      if (rem_n == '0) begin
        instr_n = INSTR_CLR;
      end else if (!fifo_empty) begin
        fifo_pop = 1'b1;
        instr_n  = (state_n == ST_FIRST) ? INSTR_MUL : INSTR_ACC;
        mplr_n   = fifo_dout[2*OP_W-1:OP_W];
        mcnd_n   = fifo_dout[OP_W-1:0];
        rem_n    = rem_n - LEN_ONE;
      end else begin
        stall_n = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      sat_q   <= 1'b0;
      stall_q <= 1'b0;
      done_q  <= 1'b0;
      run_q   <= 1'b0;
      instr_q <= INSTR_ACC;
      mplr_q  <= '0;
      mcnd_q  <= '0;
    end else begin
      state_q <= state_n;
      rem_q   <= rem_n;
      sat_q   <= sat_n;
      stall_q <= stall_n;
      done_q  <= done_n;
      run_q   <= 1'b1;
      instr_q <= instr_n;
      mplr_q  <= mplr_n;
      mcnd_q  <= mcnd_n;
    end
  end

endmodule

// File: tb/tb_mac_dot_seq.sv
// Bench for mac_dot_seq: a behavioural MAC follows the issued instruction
// stream; issued ops are scored against an expected queue and job results
// against constant or bench-summed dot products.
module tb_mac_dot_seq;
  import mac_pkg::*;

  typedef logic [7:0][15:0] op_arr_t;
  typedef struct packed {
    logic [7:0]  len;
    logic        sat;
    op_arr_t     a;
    op_arr_t     b;
    logic [39:0] res;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        job_valid = 1'b0;
  logic        job_ready;
  logic [7:0]  job_len = '0;
  logic        job_sat = 1'b0;
  logic        op_valid = 1'b0;
  logic        op_ready;
  logic [15:0] op_a = '0;
  logic [15:0] op_b = '0;
  logic [2:0]  instruction;
  logic [15:0] multiplier;
  logic [15:0] multiplicand;
  logic        stall;
  logic        busy;
  logic        done;
  logic [2:0]  dbg_state;

  logic [34:0]        exp_q[$];
  int                 n_cmp = 0;
  int                 n_err = 0;
  int                 cyc = 0;
  int                 last_issue = 0;
  int                 done_cnt = 0;
  int                 stall_cnt = 0;
  logic signed [39:0] mac_acc = '0;
  logic signed [39:0] done_result = '0;

  mac_dot_seq #(.DEPTH(4), .LEN_W(8)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .job_valid    (job_valid),
    .job_ready    (job_ready),
    .job_len      (job_len),
    .job_sat      (job_sat),
    .op_valid     (op_valid),
    .op_ready     (op_ready),
    .op_a         (op_a),
    .op_b         (op_b),
    .instruction  (instruction),
    .multiplier   (multiplier),
    .multiplicand (multiplicand),
    .stall        (stall),
    .busy         (busy),
    .done         (done),
    .dbg_state    (dbg_state)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // MAC model and issue monitor, sampled where the MAC samples
  always @(negedge clk) begin
    if (!reset_n) begin
      mac_acc = '0;
    end else begin
      if (stall) begin
        stall_cnt++;
        check("stall_hold", {5'b0, instruction, multiplier, multiplicand}, {5'b0, INSTR_ACC, 32'h0});
      end
      if (instruction != INSTR_ACC || multiplier != 16'h0 || multiplicand != 16'h0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_op", {5'b0, instruction, multiplier, multiplicand}, 40'h0);
        end else begin
          check("issued_op", {5'b0, instruction, multiplier, multiplicand}, {5'b0, exp_q.pop_front()});
        end
        case (instruction)
          INSTR_CLR: mac_acc = '0;
          INSTR_MUL: mac_acc = $signed(multiplier) * $signed(multiplicand);
          INSTR_ACC: mac_acc = mac_acc + $signed(multiplier) * $signed(multiplicand);
          INSTR_SAT: begin
            if (mac_acc > 40'sh007FFFFFFF) mac_acc = 40'sh007FFFFFFF;
            else if (mac_acc < -40'sh0080000000) mac_acc = -40'sh0080000000;
          end
          default: ;
        endcase
        last_issue = cyc;
      end
      if (done) begin
        done_cnt++;
        check("done_latency", 40'(cyc - last_issue), 40'd2);
        done_result = mac_acc;
      end
    end
  end

  // Driver tasks
  task automatic push_pair(input logic [15:0] a, input logic [15:0] b);
    logic rdy;
    op_valid = 1'b1;
    op_a = a;
    op_b = b;
    for (int t = 0; t < 200; t++) begin
      rdy = op_ready;
      @(posedge clk);
      #1;
      if (rdy) begin
        op_valid = 1'b0;
        return;
      end
    end
    op_valid = 1'b0;
    check("push_timeout", 40'd0, 40'd1);
  endtask

  task automatic start_job(input logic [7:0] len, input logic sat, input op_arr_t a, input op_arr_t b);
    logic rdy;
    for (int i = 0; i < int'(len); i++)
      exp_q.push_back({(i == 0) ? INSTR_MUL : INSTR_ACC, a[i], b[i]});
    if (len == 8'd0) exp_q.push_back({INSTR_CLR, 32'h0});
    else if (sat) exp_q.push_back({INSTR_SAT, 32'h0});
    job_valid = 1'b1;
    job_len = len;
    job_sat = sat;
    for (int t = 0; t < 200; t++) begin
      rdy = job_ready;
      @(posedge clk);
      #1;
      if (rdy) begin
        job_valid = 1'b0;
        return;
      end
    end
    job_valid = 1'b0;
    check("job_accept_timeout", 40'd0, 40'd1);
  endtask

  task automatic wait_done(input int budget);
    int start;
    start = done_cnt;
    for (int t = 0; t < budget; t++) begin
      @(posedge clk);
      #1;
      if (done_cnt != start) return;
    end
    check("done_timeout", 40'd0, 40'd1);
  endtask

  function automatic vec_t mk(input logic [7:0] len, input logic sat,
                              input logic [15:0] a0, b0, a1, b1, a2, b2,
                              input logic [39:0] res);
    vec_t v;
    v = '0;
    v.len = len;
    v.sat = sat;
    v.a[0] = a0; v.b[0] = b0;
    v.a[1] = a1; v.b[1] = b1;
    v.a[2] = a2; v.b[2] = b2;
    v.res = res;
    return v;
  endfunction

  vec_t vecs[5];

  initial begin
    op_arr_t ra, rb;
    logic signed [39:0] sum;
    int len, d0;

    vecs[0] = mk(8'd3, 1'b0, 16'd2, 16'd3, 16'd4, 16'd5, 16'hFFFF, 16'd7, 40'h00_00000013);
    vecs[1] = mk(8'd0, 1'b0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 40'h00_00000000);
    vecs[2] = mk(8'd3, 1'b1, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 40'h00_7FFFFFFF);
    vecs[3] = mk(8'd3, 1'b0, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 40'h00_C0000000);
    vecs[4] = mk(8'd2, 1'b0, 16'hFFFB, 16'd6, 16'd100, 16'hFF38, 16'd0, 16'd0, 40'hFF_FFFFB1C2);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_instruction", 40'(instruction), 40'(INSTR_ACC));
    check("rst_operands", 40'({multiplier, multiplicand}), 40'h0);
    check("rst_flags", 40'({stall, done, busy, job_ready, op_ready}), 40'h0);
    check("rst_state", 40'(dbg_state), 40'(ST_IDLE));
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_ready", 40'({job_ready, op_ready}), 40'h3);

    // Table-driven jobs
    foreach (vecs[i]) begin
      for (int j = 0; j < int'(vecs[i].len); j++) push_pair(vecs[i].a[j], vecs[i].b[j]);
      start_job(vecs[i].len, vecs[i].sat, vecs[i].a, vecs[i].b);
      wait_done(60);
      check($sformatf("result_v%0d", i), done_result, vecs[i].res);
      check("queue_drained", 40'(exp_q.size()), 40'd0);
      check("idle_after_done", 40'({busy, job_ready}), 40'h1);
    end

    // Starved job: one pair preloaded, the rest arrive late
    push_pair(16'd2, 16'd3);
    stall_cnt = 0;
    start_job(8'd3, 1'b0, vecs[0].a, vecs[0].b);
    repeat (2) @(posedge clk);
    #1;
    push_pair(16'd4, 16'd5);
    push_pair(16'hFFFF, 16'd7);
    wait_done(60);
    check("stall_cycles", 40'(stall_cnt), 40'd3);
    check("result_stalled", done_result, 40'h00_00000013);

    // FIFO fill with no job pending; fifth pair waits for the first pop
    for (int i = 1; i <= 4; i++) push_pair(16'(i), 16'(i));
    check("full_after_4", 40'(op_ready), 40'd0);
    op_valid = 1'b1;
    op_a = 16'd5;
    op_b = 16'd5;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("held_while_full", 40'(op_ready), 40'd0);
    end
    for (int i = 0; i < 8; i++) begin
      ra[i] = 16'(i + 1);
      rb[i] = 16'(i + 1);
    end
    fork
      push_pair(16'd5, 16'd5);
      start_job(8'd5, 1'b0, ra, rb);
    join
    wait_done(60);
    check("result_fill", done_result, 40'd55);

    // Reset in the middle of a starved job
    push_pair(16'd1, 16'd2);
    push_pair(16'd3, 16'd4);
    ra = '0;
    rb = '0;
    ra[0] = 16'd1; rb[0] = 16'd2; ra[1] = 16'd3; rb[1] = 16'd4;
    ra[2] = 16'd5; rb[2] = 16'd6; ra[3] = 16'd7; rb[3] = 16'd8;
    d0 = done_cnt;
    start_job(8'd4, 1'b0, ra, rb);
    repeat (4) @(posedge clk);
    #1;
    check("mid_job_busy", 40'({busy, stall}), 40'h3);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    check("abort_instruction", 40'({instruction, multiplier, multiplicand}), {5'b0, INSTR_ACC, 32'h0});
    check("abort_flags", 40'({stall, done, busy, job_ready, op_ready}), 40'h0);
    reset_n = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    check("abort_ready", 40'({job_ready, op_ready}), 40'h3);
    repeat (3) @(posedge clk);
    #1;
    check("abort_no_done", 40'(done_cnt - d0), 40'd0);
    check("abort_fifo_empty", 40'(busy), 40'd0);
    push_pair(16'd3, 16'd3);
    ra = '0;
    rb = '0;
    ra[0] = 16'd3;
    rb[0] = 16'd3;
    start_job(8'd1, 1'b0, ra, rb);
    wait_done(60);
    check("result_after_abort", done_result, 40'd9);

    // Random jobs, expected sum accumulated in the bench
    for (int n = 0; n < 6; n++) begin
      len = $urandom_range(1, 4);
      ra = '0;
      rb = '0;
      sum = '0;
      for (int j = 0; j < len; j++) begin
        ra[j] = 16'($urandom_range(0, 65535));
        rb[j] = 16'($urandom_range(0, 65535));
        if (ra[j] == 16'h0 && rb[j] == 16'h0) ra[j] = 16'd1;
        sum = sum + $signed(ra[j]) * $signed(rb[j]);
      end
      for (int j = 0; j < len; j++) push_pair(ra[j], rb[j]);
      start_job(8'(len), 1'b0, ra, rb);
      wait_done(60);
      check("result_random", done_result, sum);
    end

    repeat (2) @(posedge clk);
    check("final_queue", 40'(exp_q.size()), 40'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
